// File: rtl/rx_frame_arbiter.sv
// rx_frame_arbiter
// Frame-granular round-robin arbiter that shares one MAC decoder between four RMII RX
// frame FIFOs. A grant is held until the decoder signals end of frame. A watchdog forces
// the grant off after TIMEOUT_CYCLES, so a stuck frame cannot starve the other ports.
// Every release is followed by a short idle gap before the next arbitration. Per-port
// grant counters are exported for monitoring.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   req          per-port frame_exist level from the RX FIFOs
//   port_mask    1 = port excluded from new arbitration
//   dec_ready    decoder idle and able to accept a new frame
//   dec_eof      1-cycle pulse: decoder finished the current frame
//   grant        one-hot read-select to the decoder, 0 when nothing is granted
//   grant_valid  a grant is being held
//   grant_port   binary index of the granted port; holds its last value when idle
//   abort        1-cycle pulse: the grant was released by the watchdog
//   grant_cnt    per-port grants issued; port i at [i*CNT_WIDTH +: CNT_WIDTH]
module rx_frame_arbiter #(
  parameter int unsigned PORT_NUM       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORT_NUM-1:0]           req,
  input  logic [PORT_NUM-1:0]           port_mask,
  input  logic                          dec_ready,
  input  logic                          dec_eof,
  output logic [PORT_NUM-1:0]           grant,
  output logic                          grant_valid,
  output logic [1:0]                    grant_port,
  output logic                          abort,
  output logic [PORT_NUM*CNT_WIDTH-1:0] grant_cnt
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e                        state_q, state_d;
  logic [TimerW-1:0]             timer_q, timer_d;
  logic [GapW-1:0]               gap_q, gap_d;
  logic [1:0]                    ptr_q, ptr_d;
  logic [PORT_NUM-1:0]           grant_q, grant_d;
  logic                          valid_q, valid_d;
  logic [1:0]                    port_q, port_d;
  logic                          abort_q, abort_d;
  logic [PORT_NUM*CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [PORT_NUM-1:0] eligible;
  logic                found;
  logic [1:0]          sel;
  logic [1:0]          idx;
  logic                release_grant;

  // Rotating priority scan: ptr, ptr+1, ... (2-bit wrap gives mod 4)
  always_comb begin
    eligible = req & ~port_mask;
    found    = 1'b0;
    sel      = 2'd0;
    idx      = 2'd0;
    for (int i = 0; i < PORT_NUM; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    gap_d         = gap_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    valid_d       = valid_q;
    port_d        = port_q;
    abort_d       = 1'b0;
    cnt_d         = cnt_q;
    release_grant = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found && dec_ready) begin
          grant_d = PORT_NUM'(1) << sel;
          valid_d = 1'b1;
          port_d  = sel;
          cnt_d[int'(sel)*CNT_WIDTH +: CNT_WIDTH] =
              cnt_q[int'(sel)*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
          ptr_d   = sel + 2'd1;
          timer_d = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // End of frame has priority over a simultaneous watchdog expiry
        if (dec_eof) begin
          release_grant = 1'b1;
        end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
          release_grant = 1'b1;
          abort_d       = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
        if (release_grant) begin
          grant_d = '0;
          valid_d = 1'b0;
          gap_d   = '0;
          // The IDLE arbitration cycle is the last low cycle of the gap
          state_d = (GAP_CYCLES > 1) ? StGap : StIdle;
        end
      end
      StGap: begin
        gap_d = gap_q + GapW'(1);
        if (gap_q == GapW'(GAP_CYCLES - 2)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      gap_q   <= '0;
      ptr_q   <= 2'd0;
      grant_q <= '0;
      valid_q <= 1'b0;
      port_q  <= 2'd0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      port_q  <= port_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_port  = port_q;
  assign abort       = abort_q;
  assign grant_cnt   = cnt_q;

endmodule
